// File: rtl/instr_decode_reg_pkg.sv
// Shared definitions for the instruction-register / decode stage:
// MIPS primary opcodes and the skid-buffer occupancy states.
package instr_decode_reg_pkg;

    // MIPS primary opcodes (Instr[31:26])
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // Buffer occupancy: no entries, head only, head plus skid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } id_state_e;

endpackage

// File: rtl/instr_decode_reg_ext_sel_decode.sv
// Opcode decode for the immediate extension mode fed to SignZeroExtend.
// With ID_ILLEGAL_OP_EN defined, also flags opcodes outside the supported set.
module ext_sel_decode
    import instr_decode_reg_pkg::*;
(
    input  logic [5:0] op,
    output logic       ext_sel
`ifdef ID_ILLEGAL_OP_EN
    ,
    output logic       illegal_op
`endif
);

    // Sign-extend for arithmetic-immediate, branch and load/store opcodes
    always_comb begin
        ext_sel = 1'b0;
        case (op)
            OP_REGIMM, OP_BEQ, OP_BNE,
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_LW, OP_SW: ext_sel = 1'b1;
            default:      ext_sel = 1'b0;
        endcase
    end

`ifdef ID_ILLEGAL_OP_EN
    // Any opcode not in the supported list is illegal
    always_comb begin
        illegal_op = 1'b1;
        case (op)
            OP_RTYPE, OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE,
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
            OP_LW, OP_SW: illegal_op = 1'b0;
            default:      illegal_op = 1'b1;
        endcase
    end
`endif

endmodule

// File: rtl/instr_decode_reg.sv
// Instruction register / decode stage upstream of SignZeroExtend.
// Two-entry skid buffer (head + skid) with valid/ready on both sides,
// branch flush, and field slicing of the head instruction.
// Optional feature: define ID_ILLEGAL_OP_EN to add the IllegalOp output.
module instr_decode_reg
    import instr_decode_reg_pkg::*;
#(
    parameter int          PC_W        = 32,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0000
)(
    input  logic            CLK,
    input  logic            RST,
    input  logic            Flush,
    input  logic            InValid,
    output logic            InReady,
    input  logic [31:0]     InInstr,
    input  logic [PC_W-1:0] InPC4,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [31:0]     OutInstr,
    output logic [PC_W-1:0] OutPC4,
    output logic [5:0]      Op,
    output logic [5:0]      Funct,
    output logic [4:0]      Rs,
    output logic [4:0]      Rt,
    output logic [4:0]      Rd,
    output logic [4:0]      Sa,
    output logic [15:0]     Immediate,
    output logic            ExtSel,
    output logic [25:0]     JumpTarget
`ifdef ID_ILLEGAL_OP_EN
    ,
    output logic            IllegalOp
`endif
);

    id_state_e       state_r;
    id_state_e       state_nxt_s;
    logic [31:0]     head_instr_r;
    logic [PC_W-1:0] head_pc4_r;
    logic [31:0]     skid_instr_r;
    logic [PC_W-1:0] skid_pc4_r;

    logic in_ready_s;
    logic out_valid_s;
    logic accept_s;
    logic emit_s;
    logic load_head_s;
    logic load_skid_s;
    logic skid_to_head_s;

    // Handshake flags depend on state only, so InReady has no input path
    assign in_ready_s  = (state_r != ST_FULL);
    assign out_valid_s = (state_r != ST_EMPTY);
    assign accept_s    = InValid & in_ready_s;
    assign emit_s      = out_valid_s & OutReady;

    // Next-state and data-movement decode for the skid buffer
    always_comb begin
        state_nxt_s    = state_r;
        load_head_s    = 1'b0;
        load_skid_s    = 1'b0;
        skid_to_head_s = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    load_head_s = 1'b1;
                    state_nxt_s = ST_HALF;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_HALF: begin
                if (accept_s && emit_s) begin
                    load_head_s = 1'b1;
                    state_nxt_s = ST_HALF;
                end else if (accept_s) begin
                    load_skid_s = 1'b1;
                    state_nxt_s = ST_FULL;
                end else if (emit_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_HALF;
                end
            end
            ST_FULL: begin
                if (emit_s) begin
                    skid_to_head_s = 1'b1;
                    state_nxt_s    = ST_HALF;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // State and entry registers; reset and flush both return to a clean nop-filled buffer
    always_ff @(posedge CLK) begin
        if (RST || Flush) begin
            state_r      <= ST_EMPTY;
            head_instr_r <= RESET_INSTR;
            head_pc4_r   <= {PC_W{1'b0}};
            skid_instr_r <= RESET_INSTR;
            skid_pc4_r   <= {PC_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (load_head_s) begin
                head_instr_r <= InInstr;
                head_pc4_r   <= InPC4;
            end else if (skid_to_head_s) begin
                head_instr_r <= skid_instr_r;
                head_pc4_r   <= skid_pc4_r;
            end
            if (load_skid_s) begin
                skid_instr_r <= InInstr;
                skid_pc4_r   <= InPC4;
            end
        end
    end

    assign InReady    = in_ready_s;
    assign OutValid   = out_valid_s;
    assign OutInstr   = head_instr_r;
    assign OutPC4     = head_pc4_r;
    assign Op         = head_instr_r[31:26];
    assign Rs         = head_instr_r[25:21];
    assign Rt         = head_instr_r[20:16];
    assign Rd         = head_instr_r[15:11];
    assign Sa         = head_instr_r[10:6];
    assign Funct      = head_instr_r[5:0];
    assign Immediate  = head_instr_r[15:0];
    assign JumpTarget = head_instr_r[25:0];

`ifdef ID_ILLEGAL_OP_EN
    logic illegal_op_s;

    ext_sel_decode u_ext_sel_decode (
        .op         (head_instr_r[31:26]),
        .ext_sel    (ExtSel),
        .illegal_op (illegal_op_s)
    );

    assign IllegalOp = out_valid_s & illegal_op_s;
`else
    ext_sel_decode u_ext_sel_decode (
        .op      (head_instr_r[31:26]),
        .ext_sel (ExtSel)
    );
`endif

endmodule

// File: tb/tb_instr_decode_reg.sv
// Self-checking bench for instr_decode_reg: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_instr_decode_reg;

    logic        CLK;
    logic        RST;
    logic        Flush;
    logic        InValid;
    logic        InReady;
    logic [31:0] InInstr;
    logic [31:0] InPC4;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] OutInstr;
    logic [31:0] OutPC4;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic [4:0]  Sa;
    logic [15:0] Immediate;
    logic        ExtSel;
    logic [25:0] JumpTarget;
`ifdef ID_ILLEGAL_OP_EN
    logic        IllegalOp;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO of buffered words plus the word last seen at the head
    logic [31:0] mq_instr[$];
    logic [31:0] mq_pc[$];
    logic [31:0] m_head_instr;
    logic [31:0] m_head_pc;

    instr_decode_reg #(.PC_W(32), .RESET_INSTR(32'h0000_0000)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Flush      (Flush),
        .InValid    (InValid),
        .InReady    (InReady),
        .InInstr    (InInstr),
        .InPC4      (InPC4),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .OutInstr   (OutInstr),
        .OutPC4     (OutPC4),
        .Op         (Op),
        .Funct      (Funct),
        .Rs         (Rs),
        .Rt         (Rt),
        .Rd         (Rd),
        .Sa         (Sa),
        .Immediate  (Immediate),
        .ExtSel     (ExtSel),
        .JumpTarget (JumpTarget)
`ifdef ID_ILLEGAL_OP_EN
        ,
        .IllegalOp  (IllegalOp)
`endif
    );

    // Free-running clock, 10 time-unit period
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_ext_sel(input logic [5:0] op);
        return op inside {6'h01, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B};
    endfunction

    function automatic logic exp_legal(input logic [5:0] op);
        return op inside {6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                          6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    endfunction

    task automatic check_all();
        logic [5:0] op;
        op = 6'((m_head_instr >> 26) & 32'd63);
        check("out_valid",  {63'd0, OutValid}, {63'd0, (mq_instr.size() > 0)});
        check("in_ready",   {63'd0, InReady},  {63'd0, (mq_instr.size() < 2)});
        check("out_instr",  {32'd0, OutInstr}, {32'd0, m_head_instr});
        check("out_pc4",    {32'd0, OutPC4},   {32'd0, m_head_pc});
        check("op",         {58'd0, Op},       64'(op));
        check("rs",         {59'd0, Rs},       64'((m_head_instr >> 21) & 32'd31));
        check("rt",         {59'd0, Rt},       64'((m_head_instr >> 16) & 32'd31));
        check("rd",         {59'd0, Rd},       64'((m_head_instr >> 11) & 32'd31));
        check("sa",         {59'd0, Sa},       64'((m_head_instr >> 6) & 32'd31));
        check("funct",      {58'd0, Funct},    64'(m_head_instr & 32'd63));
        check("immediate",  {48'd0, Immediate}, 64'(m_head_instr % 32'd65536));
        check("jump_target",{38'd0, JumpTarget}, 64'(m_head_instr % 32'd67108864));
        check("ext_sel",    {63'd0, ExtSel},   {63'd0, exp_ext_sel(op)});
`ifdef ID_ILLEGAL_OP_EN
        check("illegal_op", {63'd0, IllegalOp}, {63'd0, (mq_instr.size() > 0) && !exp_legal(op)});
`endif
    endtask

    // One clock: apply inputs, advance model and DUT, check all outputs #1 after the edge
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl, input logic rst);
        bit acc;
        bit emi;
        InValid  = v;
        InInstr  = ins;
        InPC4    = pc;
        OutReady = ordy;
        Flush    = fl;
        RST      = rst;
        acc = v && (mq_instr.size() < 2);
        emi = ordy && (mq_instr.size() > 0);
        @(posedge CLK);
        if (rst || fl) begin
            mq_instr.delete();
            mq_pc.delete();
            m_head_instr = 32'h0000_0000;
            m_head_pc    = 32'h0000_0000;
        end else begin
            if (emi) begin
                void'(mq_instr.pop_front());
                void'(mq_pc.pop_front());
            end
            if (acc) begin
                mq_instr.push_back(ins);
                mq_pc.push_back(pc);
            end
        end
        if (mq_instr.size() > 0) begin
            m_head_instr = mq_instr[0];
            m_head_pc    = mq_pc[0];
        end
        #1;
        check_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  ops[16];
        logic [5:0]  op;
        logic [31:0] r;
        ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
        r = $urandom();
        if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
        else op = ops[$urandom_range(0, 15)];
        return {op, r[25:0]};
    endfunction

    initial begin
        logic [31:0] sz_ext;
        InValid = 1'b0; InInstr = 32'h0; InPC4 = 32'h0;
        OutReady = 1'b0; Flush = 1'b0; RST = 1'b1;
        m_head_instr = 32'h0; m_head_pc = 32'h0;

        // Reset held two cycles
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("rst_out_valid", {63'd0, OutValid}, 64'd0);
        check("rst_in_ready",  {63'd0, InReady},  64'd1);
        check("rst_imm",       {48'd0, Immediate}, 64'd0);
        check("rst_ext_sel",   {63'd0, ExtSel},   64'd0);

        // Single addi pass-through, one-cycle latency
        step(1'b1, 32'h2008_FFF9, 32'h0000_0004, 1'b1, 1'b0, 1'b0);
        check("addi_valid", {63'd0, OutValid}, 64'd1);
        check("addi_op",    {58'd0, Op},       64'h08);
        check("addi_rt",    {59'd0, Rt},       64'd8);
        check("addi_imm",   {48'd0, Immediate}, 64'hFFF9);
        check("addi_ext",   {63'd0, ExtSel},   64'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Zero-extended ori immediate
        step(1'b1, 32'h3508_8000, 32'h0000_0008, 1'b1, 1'b0, 1'b0);
        sz_ext = ExtSel ? {{16{Immediate[15]}}, Immediate} : {16'h0000, Immediate};
        check("ori_op",   {58'd0, Op},    64'h0D);
        check("ori_ext",  {63'd0, ExtSel}, 64'd0);
        check("ori_szext", {32'd0, sz_ext}, 64'h0000_8000);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Stall and skid: A, B buffered while downstream stalls, then drained in order
        step(1'b1, 32'h8C01_0004, 32'h0000_0010, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hAC01_0008, 32'h0000_0014, 1'b0, 1'b0, 1'b0);
        check("skid_in_ready", {63'd0, InReady}, 64'd0);
        check("skid_head_a",   {32'd0, OutInstr}, 64'h8C01_0004);
        step(1'b1, 32'h1111_1111, 32'h0000_0018, 1'b0, 1'b0, 1'b0);
        check("stall_hold_a",  {32'd0, OutInstr}, 64'h8C01_0004);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("drain_b",       {32'd0, OutInstr}, 64'hAC01_0008);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("drain_ready",   {63'd0, InReady}, 64'd1);

        // Flush from FULL with a word offered in the same cycle
        step(1'b1, 32'h2002_0001, 32'h0000_0020, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h2003_0002, 32'h0000_0024, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h2004_0003, 32'h0000_0028, 1'b0, 1'b1, 1'b0);
        check("flush_valid", {63'd0, OutValid}, 64'd0);
        check("flush_ready", {63'd0, InReady},  64'd1);
        check("flush_op",    {58'd0, Op},       64'd0);

        // Back-to-back streaming, one word per cycle
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'h2400_0000 + 32'(i * 17), 32'h0000_0100 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
            check("b2b_instr", {32'd0, OutInstr}, {32'd0, 32'h2400_0000 + 32'(i * 17)});
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom(),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 149) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
